scarv_cop_palu_issue: RTL and testbench
=======================================

Name: scarv_cop_palu_issue

Overview:
- Issue and writeback stage placed directly upstream of the packed ALU.
- Accepts decoded coprocessor instructions from the decoder through a valid/ready handshake.
- Reads CPR operands and holds them stable while the packed ALU executes. Single-cycle and multi-cycle ALU operations are handled the same way.
- Commits the byte-enabled ALU result to the CPR file and reports completion. At most one instruction is in flight at any time.

Parameters:
- CPR_AW, 4, CPR address width (2**CPR_AW registers).

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- id_valid  in  1  decoded instruction valid
- id_ready  out  1  stage can accept an instruction
- id_class  in  3  instruction class
- id_subclass  in  5  instruction subclass
- id_pw  in  3  pack width
- id_imm  in  32  immediate
- id_crs1 / id_crs2 / id_crs3  in  CPR_AW each  source CPR addresses
- id_crd  in  CPR_AW  destination CPR address
- id_gpr_rs1  in  32  GPR source value
- flush  in  1  abort any not-yet-written instruction
- cpr_rs1_addr / cpr_rs2_addr / cpr_rs3_addr  out  CPR_AW each  CPR read addresses (combinational register file)
- cpr_rs1_rdata / cpr_rs2_rdata / cpr_rs3_rdata  in  32 each  CPR read data
- palu_ivalid  out  1  instruction valid to the ALU
- palu_idone  in  1  ALU instruction complete
- palu_class / palu_subclass / palu_pw / palu_imm  out  3 / 5 / 3 / 32  registered instruction fields
- palu_gpr_rs1 / palu_rs1 / palu_rs2 / palu_rs3  out  32 each  registered operands
- palu_cpr_rd_ben  in  4  ALU writeback byte enables
- palu_cpr_rd_wdata  in  32  ALU writeback data
- cpr_rd_wen  out  4  CPR byte write enables
- cpr_rd_addr  out  CPR_AW  CPR write address
- cpr_rd_wdata  out  32  CPR write data
- issue_done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous, active-low, one clock domain. All registers reset to 0 and the state resets to IDLE.
- Reset values of outputs: id_ready=1, palu_ivalid=0, cpr_rd_wen=0, issue_done=0, busy=0.
- cpr_rsN_addr = id_crsN combinationally, always.
- States are IDLE, EXEC and WB.
  - IDLE: id_ready=1. On id_valid&&!flush, latch all id_* fields, id_crd and the three CPR operands, then go to EXEC.
  - EXEC: id_ready=0, palu_ivalid=1. Operands and fields are held constant.
    - On palu_idone: capture palu_cpr_rd_ben, palu_cpr_rd_wdata and crd into the WB registers, then go to WB.
    - With no palu_idone: stay in EXEC, with no timeout.
  - WB: cpr_rd_wen=ben, cpr_rd_addr=crd, cpr_rd_wdata=wdata, issue_done=1, id_ready=!flush.
    - On accept: go to EXEC.
    - Otherwise: go to IDLE.
- Forwarding on accept in WB: for each source N with id_crsN==crd, byte lane k of the latched operand takes wdata[k] when ben[k]=1, else cpr_rsN_rdata[k]. This is required because the CPR write lands at the same clock edge.
- ben=4'h0 (for example a cmov whose condition fails): WB still occurs and issue_done pulses. No write happens and nothing is forwarded.
- Latency: accept at cycle T, palu_ivalid high in T+1. A single-cycle ALU operation gives WB at T+2, and the CPR value is readable at T+3. Peak throughput is one instruction every 2 cycles.
- Flush:
  - In EXEC: drop palu_ivalid next cycle and go to IDLE. No write and no issue_done.
  - In WB: the write still commits and issue_done still pulses, but no new instruction is accepted.
  - flush together with id_valid in IDLE: nothing is accepted.
- Reset mid-EXEC: the instruction is discarded with no write. It is the ALU's responsibility to clear its own multiplier state.
- palu_idone while not in EXEC is ignored.

Decomposition:
- Class, subclass and pw constants come from the shared scarv_cop_common.vh. Add the state encodings (IDLE/EXEC/WB, 2 bits) there.
- One sub-module, scarv_cop_fwd_merge: a combinational per-byte bypass taking rdata, wdata, ben, addr match and producing the operand. It is instantiated three times.

Test Plan:
- Single-cycle op: CPR1=0x00000005, CPR2=0x00000003, padd pw=32, crd=4, palu_idone returned in the first EXEC cycle -> palu_ivalid high for 1 cycle; in WB, cpr_rd_wen=4'hF, addr=4, wdata=0x00000008; one issue_done pulse.
- Multi-cycle op: palu_idone delayed 4 cycles -> palu_ivalid held 4 cycles with operands constant, id_ready=0 throughout, then exactly one WB.
- Back-to-back dependency: first op writes CPR4=0x11223344 with ben=4'b0101, old CPR4=0xAABBCCDD, second op accepted in WB with crs1=4 -> palu_rs1=0xAA22CC44.
- Cmov with ben=0 -> issue_done pulses, cpr_rd_wen=0, state returns to IDLE.
- flush in the 2nd EXEC cycle -> IDLE next cycle, no write, no issue_done. flush asserted in WB -> write of 0xDEADBEEF still commits, id_ready=0.
- g_resetn asserted asynchronously mid-EXEC -> palu_ivalid, busy and cpr_rd_wen fall to 0 without waiting for a clock edge; id_ready=1.

Source files
------------

// File: rtl/scarv_cop_palu_issue_pkg.sv
// Shared definitions for the packed-ALU issue/writeback stage: state encoding,
// instruction-class constants and the latched instruction-field bundle.
package scarv_cop_palu_issue_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } issue_state_e;

   localparam logic [2:0] CLASS_PACKED_ARITH = 3'b001;
   localparam logic [4:0] SUBCLASS_PADD      = 5'b00001;
   localparam logic [4:0] SUBCLASS_CMOV      = 5'b01000;
   localparam logic [2:0] PW_32              = 3'b001;

   typedef struct packed {
      logic [2:0]  cls;
      logic [4:0]  subclass;
      logic [2:0]  pw;
      logic [31:0] imm;
      logic [31:0] gpr_rs1;
   } instr_fields_t;

endpackage

// File: rtl/scarv_cop_palu_issue_fwd_merge.sv
// Per-byte bypass: selects the retiring write data for enabled lanes of a
// matching source register, otherwise passes the register-file read data.
module scarv_cop_fwd_merge (
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic [3:0]  ben,
   input  logic        match,
   output logic [31:0] operand
);

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign operand[8*k +: 8] = (match && ben[k]) ? wdata[8*k +: 8] : rdata[8*k +: 8];
   end

endmodule

// File: rtl/scarv_cop_palu_issue.sv
// Issue/writeback stage in front of the packed ALU: latches one decoded
// instruction and its CPR operands, waits for the ALU, then commits the result.
module scarv_cop_palu_issue
   import scarv_cop_palu_issue_pkg::*;
#(
   parameter int CPR_AW = 4
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [2:0]        id_class,
   input  logic [4:0]        id_subclass,
   input  logic [2:0]        id_pw,
   input  logic [31:0]       id_imm,
   input  logic [CPR_AW-1:0] id_crs1,
   input  logic [CPR_AW-1:0] id_crs2,
   input  logic [CPR_AW-1:0] id_crs3,
   input  logic [CPR_AW-1:0] id_crd,
   input  logic [31:0]       id_gpr_rs1,
   input  logic              flush,
   output logic [CPR_AW-1:0] cpr_rs1_addr,
   output logic [CPR_AW-1:0] cpr_rs2_addr,
   output logic [CPR_AW-1:0] cpr_rs3_addr,
   input  logic [31:0]       cpr_rs1_rdata,
   input  logic [31:0]       cpr_rs2_rdata,
   input  logic [31:0]       cpr_rs3_rdata,
   output logic              palu_ivalid,
   input  logic              palu_idone,
   output logic [2:0]        palu_class,
   output logic [4:0]        palu_subclass,
   output logic [2:0]        palu_pw,
   output logic [31:0]       palu_imm,
   output logic [31:0]       palu_gpr_rs1,
   output logic [31:0]       palu_rs1,
   output logic [31:0]       palu_rs2,
   output logic [31:0]       palu_rs3,
   input  logic [3:0]        palu_cpr_rd_ben,
   input  logic [31:0]       palu_cpr_rd_wdata,
   output logic [3:0]        cpr_rd_wen,
   output logic [CPR_AW-1:0] cpr_rd_addr,
   output logic [31:0]       cpr_rd_wdata,
   output logic              issue_done,
   output logic              busy
);

   issue_state_e      state;
   instr_fields_t     fields;
   logic [CPR_AW-1:0] ex_crd;
   logic [CPR_AW-1:0] wb_crd;
   logic [3:0]        wb_ben;
   logic [31:0]       wb_wdata;
   logic              accept;
   logic [31:0]       fwd_rs1, fwd_rs2, fwd_rs3;

   assign cpr_rs1_addr = id_crs1;
   assign cpr_rs2_addr = id_crs2;
   assign cpr_rs3_addr = id_crs3;

   // A flush during WB still lets the write retire but blocks the next issue.
   assign id_ready = (state == ST_IDLE) || ((state == ST_WB) && !flush);
   assign accept   = id_valid && id_ready && !flush;

   assign palu_ivalid  = (state == ST_EXEC);
   assign issue_done   = (state == ST_WB);
   assign busy         = (state != ST_IDLE);
   assign cpr_rd_wen   = issue_done ? wb_ben : 4'h0;
   assign cpr_rd_addr  = wb_crd;
   assign cpr_rd_wdata = wb_wdata;

   assign palu_class    = fields.cls;
   assign palu_subclass = fields.subclass;
   assign palu_pw       = fields.pw;
   assign palu_imm      = fields.imm;
   assign palu_gpr_rs1  = fields.gpr_rs1;

   // The CPR write commits on the same edge that latches the next operands.
   scarv_cop_fwd_merge u_fwd_rs1 (
      .rdata(cpr_rs1_rdata), .wdata(wb_wdata), .ben(wb_ben),
      .match((state == ST_WB) && (id_crs1 == wb_crd)), .operand(fwd_rs1)
   );
   scarv_cop_fwd_merge u_fwd_rs2 (
      .rdata(cpr_rs2_rdata), .wdata(wb_wdata), .ben(wb_ben),
      .match((state == ST_WB) && (id_crs2 == wb_crd)), .operand(fwd_rs2)
   );
   scarv_cop_fwd_merge u_fwd_rs3 (
      .rdata(cpr_rs3_rdata), .wdata(wb_wdata), .ben(wb_ben),
      .match((state == ST_WB) && (id_crs3 == wb_crd)), .operand(fwd_rs3)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state    <= ST_IDLE;
         fields   <= '0;
         palu_rs1 <= '0;
         palu_rs2 <= '0;
         palu_rs3 <= '0;
         ex_crd   <= '0;
         wb_crd   <= '0;
         wb_ben   <= '0;
         wb_wdata <= '0;
      end else begin
         if (accept) begin
            fields   <= '{cls: id_class, subclass: id_subclass, pw: id_pw,
                          imm: id_imm, gpr_rs1: id_gpr_rs1};
            palu_rs1 <= fwd_rs1;
            palu_rs2 <= fwd_rs2;
            palu_rs3 <= fwd_rs3;
            ex_crd   <= id_crd;
         end
         case (state)
            ST_IDLE: if (accept) state <= ST_EXEC;
            ST_EXEC: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (palu_idone) begin
                  wb_ben   <= palu_cpr_rd_ben;
                  wb_wdata <= palu_cpr_rd_wdata;
                  wb_crd   <= ex_crd;
                  state    <= ST_WB;
               end
            end
            ST_WB:   state <= accept ? ST_EXEC : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// Self-checking bench for scarv_cop_palu_issue: directed vector table, random
// transactions against an architectural CPR model, and reset/flush corners.
module tb_scarv_cop_palu_issue;
   import scarv_cop_palu_issue_pkg::*;

   typedef struct {
      logic [2:0]  cls;
      logic [4:0]  sub;
      logic [2:0]  pw;
      logic [31:0] imm;
      logic [3:0]  crs1, crs2, crs3, crd;
      logic [31:0] gpr;
      int          delay;
      int          flush_at;
      logic [3:0]  ben;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      op_t         op;
      int          fin;
      logic [31:0] e1, e2, e3;
   } vec_t;

   logic        g_clk = 1'b0, g_resetn = 1'b0;
   logic        id_valid = 1'b0, flush = 1'b0, palu_idone = 1'b0;
   logic [2:0]  id_class = '0, id_pw = '0;
   logic [4:0]  id_subclass = '0;
   logic [31:0] id_imm = '0, id_gpr_rs1 = '0, palu_cpr_rd_wdata = '0;
   logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crs3 = '0, id_crd = '0;
   logic [3:0]  palu_cpr_rd_ben = '0;
   logic        id_ready, palu_ivalid, issue_done, busy;
   logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr, cpr_rd_wen, cpr_rd_addr;
   logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata, cpr_rd_wdata;
   logic [2:0]  palu_class, palu_pw;
   logic [4:0]  palu_subclass;
   logic [31:0] palu_imm, palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3;

   logic [31:0] cpr_mem [16];
   logic [31:0] ref_cpr [16];
   logic        load_en = 1'b1;
   int          n_vec = 0, n_err = 0;
   bit          pend = 1'b0;
   op_t         pend_op;

   scarv_cop_palu_issue #(.CPR_AW(4)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .id_valid(id_valid), .id_ready(id_ready),
      .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm),
      .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3), .id_crd(id_crd),
      .id_gpr_rs1(id_gpr_rs1), .flush(flush),
      .cpr_rs1_addr(cpr_rs1_addr), .cpr_rs2_addr(cpr_rs2_addr), .cpr_rs3_addr(cpr_rs3_addr),
      .cpr_rs1_rdata(cpr_rs1_rdata), .cpr_rs2_rdata(cpr_rs2_rdata), .cpr_rs3_rdata(cpr_rs3_rdata),
      .palu_ivalid(palu_ivalid), .palu_idone(palu_idone), .palu_class(palu_class),
      .palu_subclass(palu_subclass), .palu_pw(palu_pw), .palu_imm(palu_imm),
      .palu_gpr_rs1(palu_gpr_rs1), .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
      .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
      .cpr_rd_wen(cpr_rd_wen), .cpr_rd_addr(cpr_rd_addr), .cpr_rd_wdata(cpr_rd_wdata),
      .issue_done(issue_done), .busy(busy)
   );

   always #5 g_clk = ~g_clk;

   function automatic logic [31:0] init_val(input int i);
      case (i)
         1:       return 32'h0000_0005;
         2:       return 32'h0000_0003;
         3:       return 32'h0F0F_0F0F;
         4:       return 32'hAABB_CCDD;
         default: return 32'hC0DE_0000 | i;
      endcase
   endfunction

   // Bench-side CPR file: combinational read, byte-enabled write.
   assign cpr_rs1_rdata = cpr_mem[cpr_rs1_addr];
   assign cpr_rs2_rdata = cpr_mem[cpr_rs2_addr];
   assign cpr_rs3_rdata = cpr_mem[cpr_rs3_addr];

   always @(posedge g_clk) begin
      if (load_en) begin
         for (int i = 0; i < 16; i++) cpr_mem[i] <= init_val(i);
      end else begin
         for (int k = 0; k < 4; k++)
            if (cpr_rd_wen[k]) cpr_mem[cpr_rd_addr][8*k +: 8] <= cpr_rd_wdata[8*k +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " ivalid"}, 32'(palu_ivalid), 0);
      check({tag, " issue_done"}, 32'(issue_done), 0);
      check({tag, " wen"}, 32'(cpr_rd_wen), 0);
      check({tag, " id_ready"}, 32'(id_ready), 1);
   endtask

   task automatic check_wb();
      check("wb issue_done", 32'(issue_done), 1);
      check("wb busy", 32'(busy), 1);
      check("wb ivalid", 32'(palu_ivalid), 0);
      check("wb wen", 32'(cpr_rd_wen), 32'(pend_op.ben));
      check("wb addr", 32'(cpr_rd_addr), 32'(pend_op.crd));
      check("wb wdata", cpr_rd_wdata, pend_op.wdata);
   endtask

   task automatic apply_pend();
      for (int k = 0; k < 4; k++)
         if (pend_op.ben[k]) ref_cpr[pend_op.crd][8*k +: 8] = pend_op.wdata[8*k +: 8];
      pend = 1'b0;
   endtask

   task automatic scramble_id();
      id_class = 3'($urandom); id_subclass = 5'($urandom); id_pw = 3'($urandom);
      id_imm = $urandom; id_gpr_rs1 = $urandom; id_crd = 4'($urandom);
      id_crs1 = 4'($urandom); id_crs2 = 4'($urandom); id_crs3 = 4'($urandom);
   endtask

   // Issue one op; starts either from IDLE or from the WB cycle of the pending op.
   task automatic run_op(input op_t op, input bit use_tbl, input logic [31:0] t1, t2, t3);
      logic [31:0] e1, e2, e3;
      bit flushed = 1'b0;
      @(negedge g_clk);
      id_valid = 1'b1; flush = 1'b0;
      id_class = op.cls; id_subclass = op.sub; id_pw = op.pw; id_imm = op.imm;
      id_crs1 = op.crs1; id_crs2 = op.crs2; id_crs3 = op.crs3; id_crd = op.crd;
      id_gpr_rs1 = op.gpr;
      palu_idone = 1'($urandom); palu_cpr_rd_ben = 4'($urandom); palu_cpr_rd_wdata = $urandom;
      #1;
      if (pend) check_wb(); else check_idle("accept");
      check("accept id_ready", 32'(id_ready), 1);
      check("rs1 addr", 32'(cpr_rs1_addr), 32'(op.crs1));
      if (pend) apply_pend();
      e1 = use_tbl ? t1 : ref_cpr[op.crs1];
      e2 = use_tbl ? t2 : ref_cpr[op.crs2];
      e3 = use_tbl ? t3 : ref_cpr[op.crs3];
      for (int i = 1; i <= op.delay; i++) begin
         @(negedge g_clk);
         scramble_id();
         id_valid = 1'($urandom);
         flush = (i == op.flush_at);
         palu_idone = (i == op.delay) && !flush;
         palu_cpr_rd_ben = palu_idone ? op.ben : 4'($urandom);
         palu_cpr_rd_wdata = palu_idone ? op.wdata : $urandom;
         #1;
         check("exec ivalid", 32'(palu_ivalid), 1);
         check("exec id_ready", 32'(id_ready), 0);
         check("exec busy", 32'(busy), 1);
         check("exec issue_done", 32'(issue_done), 0);
         check("exec wen", 32'(cpr_rd_wen), 0);
         check("exec rs1", palu_rs1, e1);
         check("exec rs2", palu_rs2, e2);
         check("exec rs3", palu_rs3, e3);
         check("exec fields", {palu_class, palu_subclass, palu_pw, 17'd0},
               {op.cls, op.sub, op.pw, 17'd0});
         check("exec imm", palu_imm, op.imm);
         check("exec gpr", palu_gpr_rs1, op.gpr);
         if (flush) begin
            flushed = 1'b1;
            break;
         end
      end
      if (flushed) begin
         @(negedge g_clk);
         id_valid = 1'b0; flush = 1'b0; palu_idone = 1'b0;
         #1;
         check_idle("post-flush");
      end else begin
         pend = 1'b1;
         pend_op = op;
      end
   endtask

   // Retire the pending op without chaining; optionally flush while offering a new op.
   task automatic finish_wb(input bit fl, input bit offer);
      @(negedge g_clk);
      id_valid = offer; flush = fl; palu_idone = 1'($urandom);
      #1;
      check_wb();
      check("wb id_ready", 32'(id_ready), 32'(!fl));
      apply_pend();
      @(negedge g_clk);
      id_valid = 1'b0; flush = 1'b0; palu_idone = 1'b0;
      #1;
      check_idle("post-wb");
   endtask

   vec_t vecs[6];

   initial begin
      op_t o;
      for (int i = 0; i < 16; i++) ref_cpr[i] = init_val(i);

      vecs[0] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32, 32'h1, 4'd4, 4'd2, 4'd3, 4'd4,
                         32'h100, 1, 0, 4'b0101, 32'h1122_3344},
                  fin: 0, e1: 32'hAABB_CCDD, e2: 32'h3, e3: 32'h0F0F_0F0F};
      vecs[1] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32, 32'h2, 4'd4, 4'd4, 4'd1, 4'd5,
                         32'h200, 4, 0, 4'hF, 32'h1234_5678},
                  fin: 1, e1: 32'hAA22_CC44, e2: 32'hAA22_CC44, e3: 32'h5};
      vecs[2] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32, 32'h3, 4'd1, 4'd2, 4'd0, 4'd4,
                         32'h300, 1, 0, 4'hF, 32'h0000_0008},
                  fin: 0, e1: 32'h5, e2: 32'h3, e3: 32'hC0DE_0000};
      vecs[3] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_CMOV, PW_32, 32'h4, 4'd4, 4'd2, 4'd5, 4'd2,
                         32'h400, 2, 0, 4'h0, 32'hFFFF_FFFF},
                  fin: 1, e1: 32'h8, e2: 32'h3, e3: 32'h1234_5678};
      vecs[4] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32, 32'h5, 4'd1, 4'd6, 4'd2, 4'd6,
                         32'h500, 3, 2, 4'hF, 32'h5555_5555},
                  fin: 0, e1: 32'h5, e2: 32'hC0DE_0006, e3: 32'h3};
      vecs[5] = '{op: '{CLASS_PACKED_ARITH, SUBCLASS_PADD, PW_32, 32'h6, 4'd7, 4'd4, 4'd5, 4'd7,
                         32'h600, 1, 0, 4'hF, 32'hDEAD_BEEF},
                  fin: 2, e1: 32'hC0DE_0007, e2: 32'h8, e3: 32'h1234_5678};

      // Reset: load the CPR file and check reset-time outputs.
      repeat (2) @(negedge g_clk);
      check_idle("reset");
      check("reset rs1", palu_rs1, 0);
      load_en = 1'b0;
      g_resetn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].op, 1'b1, vecs[i].e1, vecs[i].e2, vecs[i].e3);
         if (vecs[i].fin == 1) finish_wb(1'b0, 1'b0);
         if (vecs[i].fin == 2) finish_wb(1'b1, 1'b1);
      end

      // flush with id_valid in IDLE accepts nothing; idone in IDLE is ignored.
      @(negedge g_clk);
      id_valid = 1'b1; flush = 1'b1; palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF;
      @(negedge g_clk);
      id_valid = 1'b0; flush = 1'b0;
      #1;
      check_idle("idle flush");
      @(negedge g_clk);
      palu_idone = 1'b0;
      #1;
      check_idle("idle idone");

      // Random transactions against the architectural model.
      for (int n = 0; n < 60; n++) begin
         o.cls = 3'($urandom); o.sub = 5'($urandom); o.pw = 3'($urandom);
         o.imm = $urandom; o.gpr = $urandom;
         o.crs1 = (pend && $urandom_range(0, 1) == 1) ? pend_op.crd : 4'($urandom);
         o.crs2 = (pend && $urandom_range(0, 2) == 0) ? pend_op.crd : 4'($urandom);
         o.crs3 = 4'($urandom); o.crd = 4'($urandom);
         o.delay = $urandom_range(1, 5);
         o.flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, o.delay) : 0;
         o.ben = 4'($urandom); o.wdata = $urandom;
         if (pend && $urandom_range(0, 2) == 0) finish_wb(1'($urandom), 1'b0);
         run_op(o, 1'b0, '0, '0, '0);
      end
      if (pend) finish_wb(1'b0, 1'b0);

      // Asynchronous reset mid-EXEC discards the op without a clock edge.
      @(negedge g_clk);
      id_valid = 1'b1; id_crs1 = 4'd1; id_crd = 4'd9;
      @(negedge g_clk);
      id_valid = 1'b0;
      #1;
      check("pre-reset ivalid", 32'(palu_ivalid), 1);
      #1 g_resetn = 1'b0;
      #1;
      check_idle("async reset");
      check("async reset rs1", palu_rs1, 0);
      @(negedge g_clk);
      g_resetn = 1'b1;
      @(negedge g_clk);

      for (int i = 0; i < 16; i++) check($sformatf("cpr%0d", i), cpr_mem[i], ref_cpr[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
